// File: rtl/regbus2ahb_if.sv
// Register-bus request/response plus AHB master signals, bundled for the bridge.
// Latency: none, wires only.
// Backpressure: req_ready from the bridge gates requests; rsp and AHB sides carry no backpressure here.
interface regbus2ahb_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
);
    // register-bus side
    logic                      req_valid;
    logic                      req_ready;
    logic [AHB_ADDR_WIDTH-1:0] req_addr;
    logic                      req_wr1_rd0;
    logic [2:0]                req_size;
    logic [AHB_DATA_WIDTH-1:0] req_wdata;
    logic                      rsp_valid;
    logic [AHB_DATA_WIDTH-1:0] rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;
    // AHB side
    logic [AHB_ADDR_WIDTH-1:0] HADDR;
    logic [1:0]                HTRANS;
    logic                      HWRITE;
    logic [2:0]                HSIZE;
    logic [2:0]                HBURST;
    logic [AHB_DATA_WIDTH-1:0] HWDATA;
    logic                      HREADY;
    logic [1:0]                HRESP;
    logic [AHB_DATA_WIDTH-1:0] HRDATA;

    // bridge view: it is the AHB master and the register-bus target
    modport master (
        input  req_valid, req_addr, req_wr1_rd0, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    // environment view: requester plus AHB slave/mux
    modport slave (
        output req_valid, req_addr, req_wr1_rd0, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/regbus2ahb.sv
// Single-outstanding register-bus to AHB SINGLE-transfer master bridge.
// Latency: 4 cycles accept-to-ready at zero wait states, +1 per slave wait state.
// Backpressure: req_ready only in IDLE; rsp is a one-cycle pulse with no backpressure.
module regbus2ahb #(
    parameter int          AHB_ADDR_WIDTH = 32,
    parameter int          AHB_DATA_WIDTH = 32,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd256
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    regbus2ahb_if.master  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t                    state;
    state_t                    state_nxt;
    logic [15:0]               tmo_cnt;
    logic [AHB_DATA_WIDTH-1:0] wdata_q;
    logic                      accept;
    logic                      misalign;
    logic                      tmo_hit;

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.HBURST    = 3'b000;

    // Decode handshake, alignment, timeout expiry and the next state.
    always_comb begin
        state_nxt = state;
        accept    = bus.req_valid && (state == ST_IDLE);
        misalign  = (bus.req_size > 3'd2)
                 || ((bus.req_size == 3'd1) && bus.req_addr[0])
                 || ((bus.req_size == 3'd2) && (bus.req_addr[1:0] != 2'b00));
        tmo_hit   = (TIMEOUT_CYCLES != 16'd0) && !bus.HREADY
                 && (tmo_cnt == TIMEOUT_CYCLES - 16'd1);
        case (state)
            ST_IDLE: if (accept) state_nxt = misalign ? ST_RESP : ST_ADDR;
            ST_ADDR: begin
                if (bus.HREADY)   state_nxt = ST_DATA;
                else if (tmo_hit) state_nxt = ST_RESP;
            end
            ST_DATA: begin
                // an ERROR with HREADY low simply waits here for its second cycle
                if (bus.HREADY || tmo_hit) state_nxt = ST_RESP;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Wait-state counter, restarted on entry to each AHB phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tmo_cnt <= 16'd0;
        end else if ((state == ST_IDLE && state_nxt == ST_ADDR)
                  || (state == ST_ADDR && state_nxt == ST_DATA)) begin
            tmo_cnt <= 16'd0;
        end else if ((state == ST_ADDR || state == ST_DATA) && !bus.HREADY) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // Registered AHB and response outputs, updated from the current/next state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bus.HTRANS      <= HTRANS_IDLE;
            bus.HADDR       <= '0;
            bus.HWRITE      <= 1'b0;
            bus.HSIZE       <= 3'd0;
            bus.HWDATA      <= '0;
            wdata_q         <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            // NONSEQ only while in ADDR; a timeout there drops it to IDLE
            bus.HTRANS    <= (state_nxt == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            bus.rsp_valid <= (state_nxt == ST_RESP);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus.HADDR  <= bus.req_addr;
                        bus.HWRITE <= bus.req_wr1_rd0;
                        bus.HSIZE  <= bus.req_size;
                        wdata_q    <= bus.req_wdata;
                        if (misalign) begin
                            bus.rsp_err     <= 1'b1;
                            bus.rsp_timeout <= 1'b0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADY) begin
                        if (bus.HWRITE) bus.HWDATA <= wdata_q;
                    end else if (tmo_hit) begin
                        bus.rsp_err     <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bus.HREADY) begin
                        // RETRY and SPLIT are not retried; any non-OKAY is an error
                        bus.rsp_err     <= (bus.HRESP != 2'b00);
                        bus.rsp_timeout <= 1'b0;
                        if (!bus.HWRITE) bus.rsp_rdata <= bus.HRDATA;
                    end else if (tmo_hit) begin
                        bus.rsp_err     <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/regbus2ahb.md
Name: regbus2ahb

Overview:
- Single-outstanding AHB master bridge: converts a simple register-bus request/response interface into AHB SINGLE transfers.
- Lets internal initiators (debug module, DMA control, boot loader) reach AHB slaves such as the ahb-to-regbus register slaves.
- One transfer in flight at a time. Features: misalignment check, two-cycle error response handling, hung-slave timeout.

Parameters:
- AHB_ADDR_WIDTH, 32, address width (matches `AHB_ADDR_WIDTH).
- AHB_DATA_WIDTH, 32, data width (matches `AHB_DATA_WIDTH).
- TIMEOUT_CYCLES, 16'd256, HREADY-low cycles allowed before forced error completion; 0 disables the timeout.

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_addr  in  AHB_ADDR_WIDTH  byte address
- req_wr1_rd0  in  1  1=write, 0=read
- req_size  in  3  0=byte, 1=halfword, 2=word
- req_wdata  in  AHB_DATA_WIDTH  write data, already placed on the correct byte lanes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  AHB_DATA_WIDTH  read data (full HRDATA word)
- rsp_err  out  1  completion was an error (qualified by rsp_valid)
- rsp_timeout  out  1  error cause was timeout (qualified by rsp_valid)
- HADDR  out  AHB_ADDR_WIDTH  AHB address
- HTRANS  out  2  IDLE or NONSEQ only
- HWRITE  out  1  AHB direction
- HSIZE  out  3  AHB size
- HBURST  out  3  tied to SINGLE (3'b000)
- HWDATA  out  AHB_DATA_WIDTH  write data
- HREADY  in  1  transfer ready from slave / mux
- HRESP  in  2  OKAY=00, ERROR=01, RETRY=10, SPLIT=11
- HRDATA  in  AHB_DATA_WIDTH  read data

Behaviour:
- Reset is asynchronous. HRESETn low forces state IDLE immediately.
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, timeout counter=0. req_ready=1, because it is decoded from state IDLE.
- All AHB outputs and rsp_* outputs are registered. req_ready = (state==IDLE), combinational.
- States: IDLE, ADDR, DATA, RESP.
- IDLE: handshake completes when req_valid && req_ready at the clock edge. Capture addr, dir, size and wdata.
  - Aligned request -> ADDR.
  - Misaligned request -> RESP with rsp_err=1, rsp_timeout=0; no AHB transfer is issued.
  - Misaligned means: size 1 with addr[0]=1; size 2 with addr[1:0]!=0; size >2.
- ADDR: HTRANS=NONSEQ, with HADDR, HWRITE and HSIZE from the captured values.
  - HREADY=1 at the edge -> DATA.
  - HREADY=0 -> stay in ADDR holding all signals; timeout counter increments.
- DATA: HTRANS=IDLE. HWDATA = captured wdata for writes, held for the whole phase. HADDR, HWRITE and HSIZE hold.
  - HREADY=1 at the edge -> RESP. Set rsp_err=(HRESP!=OKAY). For reads, capture rsp_rdata=HRDATA; for writes, rsp_rdata keeps its previous value.
  - RETRY and SPLIT are reported as errors; there is no retry support.
  - HRESP=ERROR with HREADY=0 (first cycle of the two-cycle error) -> stay in DATA and wait for the HREADY=1 cycle.
- Timeout counter: 16 bits. Cleared on entry to ADDR and on entry to DATA; increments each cycle HREADY=0 in ADDR or DATA.
  - When counter==TIMEOUT_CYCLES-1 and HREADY=0 (TIMEOUT_CYCLES!=0) -> RESP with rsp_err=1, rsp_timeout=1. HTRANS is IDLE next cycle.
  - Timeout in ADDR abandons the NONSEQ; the slave sees HTRANS=IDLE afterwards.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_err, rsp_timeout and rsp_rdata hold until the next completion.
- Latency, zero wait states: accept edge T; NONSEQ driven in cycle T+1; data phase in T+2; rsp_valid in T+3; req_ready high again in T+4. Minimum 4 cycles per transfer.
- Each slave wait state adds one cycle.
- There is no backpressure on rsp. The requester must sample rsp_valid.
- req_* inputs are ignored outside IDLE.
- Reset mid-transfer: the transfer is aborted silently, with no rsp_valid. HTRANS returns to IDLE asynchronously.

Test Plan:
- Word read, addr 0x0000_0010, slave zero-wait with HRDATA=0xA5A5_1234 -> NONSEQ one cycle with HSIZE=2, HWRITE=0; rsp_valid 3 cycles after accept; rsp_rdata=0xA5A5_1234; rsp_err=0.
- Byte write, addr 0x13, wdata 0x7700_0000, slave inserts 2 wait states in data phase -> HWDATA=0x7700_0000 held for 3 cycles; HADDR=0x13, HSIZE=0; rsp_valid on the cycle after HREADY=1; rsp_err=0.
- Halfword request at addr 0x21 -> no NONSEQ ever driven; rsp_valid next cycle; rsp_err=1, rsp_timeout=0.
- Word read; slave returns ERROR (HREADY=0 then HREADY=1) -> rsp_err=1, rsp_timeout=0; state returns to IDLE; a following read completes OKAY.
- TIMEOUT_CYCLES=4, slave holds HREADY=0 in data phase -> after 4 low cycles: rsp_valid, rsp_err=1, rsp_timeout=1; HTRANS IDLE; req_ready=1 the cycle after.
- HRESETn asserted during a write data phase with HREADY=0 -> all outputs return to reset values immediately; no rsp_valid after release; req_ready=1.
